// File: rtl/uart_rx_word.sv
// UART receiver (8 data bits, LSB first, 1 stop bit) that keeps the last two good bytes as a display word.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_word #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic        o_parity_err,
  output logic [15:0] o_word
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  state_t           state, state_n;
  logic             rx_meta, rx_sync;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic [15:0]      word_n;
  logic             valid_n, ferr_n, perr_n;
  logic             par_mismatch;
  logic             bit_done;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_n;
`endif

  // Registers: synchronizer, FSM state, datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      o_data       <= '0;
      o_word       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
`endif
    end else begin
      rx_meta      <= i_rx;
      rx_sync      <= rx_meta;
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_n;
      shift        <= shift_n;
      o_data       <= data_n;
      o_word       <= word_n;
      o_valid      <= valid_n;
      o_frame_err  <= ferr_n;
      o_parity_err <= perr_n;
`ifdef UART_RX_PARITY_EN
      par_bit      <= par_n;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    shift_n  = shift;
    data_n   = o_data;
    word_n   = o_word;
    valid_n  = 1'b0;
    ferr_n   = 1'b0;
    perr_n   = 1'b0;
    bit_done = (cnt == CNT_LAST);
`ifdef UART_RX_PARITY_EN
    par_n        = par_bit;
    par_mismatch = ^{shift, par_bit};
`else
    par_mismatch = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_sync ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_n   = '0;
          shift_n = {rx_sync, shift[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          cnt_n   = '0;
          par_n   = rx_sync;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          cnt_n = '0;
          if (rx_sync && !par_mismatch) begin
            valid_n = 1'b1;
            data_n  = shift;
            word_n  = {o_word[7:0], shift};
            state_n = IDLE;
          end else if (rx_sync) begin
            perr_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            perr_n  = par_mismatch;
            state_n = RECOVER;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      // A held-low line after a bad stop bit must not look like a new start
      RECOVER: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed self-checking bench for uart_rx_word at CLKS_PER_BIT=16.
// Define UART_RX_PARITY_EN for both files to exercise the parity build.
module tb_uart_rx_word;

  localparam int unsigned CPB = 16;

  logic        clk;
  logic        rst;
  logic        i_rx;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_parity_err;
  logic [15:0] o_word;

  int checks = 0;
  int errors = 0;

  int n_valid = 0, n_ferr = 0, n_perr = 0, n_long = 0;
  logic prev_v = 1'b0, prev_f = 1'b0, prev_p = 1'b0;

  uart_rx_word #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_word       (o_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) n_valid++;
      if (o_frame_err) n_ferr++;
      if (o_parity_err) n_perr++;
      if ((o_valid && prev_v) || (o_frame_err && prev_f) || (o_parity_err && prev_p)) n_long++;
    end
    prev_v = o_valid;
    prev_f = o_frame_err;
    prev_p = o_parity_err;
  end

  task automatic hold(input logic v, input int cycles);
    i_rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    logic par;
    par = (^d) ^ bad_par;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold(par, CPB);
`else
    if (par === 1'bx) hold(1'b1, 0);
`endif
    hold(stop, CPB);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst  = 1'b1;
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", o_data); end
    checks++; if (o_word !== 16'h0000) begin errors++; $display("FAIL reset_word got %h exp 0000", o_word); end
    checks++; if ({o_valid, o_frame_err, o_parity_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {o_valid, o_frame_err, o_parity_err}); end
    rst = 1'b0;
    hold(1'b1, 10);
  endtask

  task automatic test_basic;
    int v0, f0, p0;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_frame(8'h5A, 1'b1, 1'b0);
    hold(1'b1, 20);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL b1_valid_count got %0d exp 1", n_valid - v0); end
    checks++; if (o_data !== 8'h5A) begin errors++; $display("FAIL b1_data got %h exp 5a", o_data); end
    checks++; if (o_word !== 16'h005A) begin errors++; $display("FAIL b1_word got %h exp 005a", o_word); end
    send_frame(8'hC3, 1'b1, 1'b0);
    hold(1'b1, 20);
    checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2_valid_count got %0d exp 2", n_valid - v0); end
    checks++; if (o_data !== 8'hC3) begin errors++; $display("FAIL b2_data got %h exp c3", o_data); end
    checks++; if (o_word !== 16'h5AC3) begin errors++; $display("FAIL b2_word got %h exp 5ac3", o_word); end
    checks++; if ((n_ferr - f0) + (n_perr - p0) !== 0) begin errors++; $display("FAIL b_err_pulses got %0d exp 0", (n_ferr - f0) + (n_perr - p0)); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    hold(1'b0, 4);
    hold(1'b1, 40);
    checks++; if ((n_valid - v0) + (n_ferr - f0) !== 0) begin errors++; $display("FAIL glitch_pulses got %0d exp 0", (n_valid - v0) + (n_ferr - f0)); end
    checks++; if (o_word !== 16'h5AC3) begin errors++; $display("FAIL glitch_word got %h exp 5ac3", o_word); end
    send_frame(8'h11, 1'b1, 1'b0);
    hold(1'b1, 20);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL glitch_next_valid got %0d exp 1", n_valid - v0); end
    checks++; if (o_data !== 8'h11) begin errors++; $display("FAIL glitch_next_data got %h exp 11", o_data); end
    checks++; if (o_word !== 16'hC311) begin errors++; $display("FAIL glitch_next_word got %h exp c311", o_word); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h81, 1'b0, 1'b0);
    hold(1'b0, 3 * CPB);
    hold(1'b1, 40);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", n_ferr - f0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d exp 0", n_valid - v0); end
    checks++; if (o_word !== 16'hC311) begin errors++; $display("FAIL ferr_word got %h exp c311", o_word); end
    checks++; if (o_data !== 8'h11) begin errors++; $display("FAIL ferr_data got %h exp 11", o_data); end
    send_frame(8'h22, 1'b1, 1'b0);
    hold(1'b1, 20);
    checks++; if (o_word !== 16'h1122) begin errors++; $display("FAIL ferr_next_word got %h exp 1122", o_word); end
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL ferr_next_valid got %0d exp 1", n_valid - v0); end
  endtask

  task automatic test_reset_mid;
    int v0, f0, p0;
    logic [7:0] d;
    d = 8'hA5;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(d[i], CPB);
    hold(d[4], CPB / 2);
    rst  = 1'b1;
    i_rx = 1'b1;
    @(negedge clk);
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", o_data); end
    checks++; if (o_word !== 16'h0000) begin errors++; $display("FAIL rstmid_word got %h exp 0000", o_word); end
    rst = 1'b0;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    hold(1'b1, 30);
    checks++; if ((n_valid - v0) + (n_ferr - f0) + (n_perr - p0) !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d exp 0", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0)); end
    send_frame(8'h0F, 1'b1, 1'b0);
    hold(1'b1, 20);
    checks++; if (o_data !== 8'h0F) begin errors++; $display("FAIL rstmid_next_data got %h exp 0f", o_data); end
    checks++; if (o_word !== 16'h000F) begin errors++; $display("FAIL rstmid_next_word got %h exp 000f", o_word); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 20);
    checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_bad_perr got %0d exp 1", n_perr - p0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL par_bad_valid got %0d exp 0", n_valid - v0); end
    checks++; if (o_word !== 16'h000F) begin errors++; $display("FAIL par_bad_word got %h exp 000f", o_word); end
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 20);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL par_good_valid got %0d exp 1", n_valid - v0); end
    checks++; if (o_data !== 8'h07) begin errors++; $display("FAIL par_good_data got %h exp 07", o_data); end
    checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_good_perr got %0d exp 1", n_perr - p0); end
  endtask
`else
  task automatic test_parity;
    int p0;
    p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 20);
    checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL nopar_perr got %0d exp 0", n_perr - p0); end
    checks++; if (o_word !== 16'h0F07) begin errors++; $display("FAIL nopar_word got %h exp 0f07", o_word); end
  endtask
`endif

  task automatic test_pulse_width;
    checks++; if (n_long !== 0) begin errors++; $display("FAIL pulse_width got %0d long pulses exp 0", n_long); end
    checks++; if (o_parity_err !== 1'b0) begin errors++; $display("FAIL perr_idle got %b exp 0", o_parity_err); end
  endtask

  initial begin
    rst  = 1'b1;
    i_rx = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_parity();
    test_pulse_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_word.md
UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit period (100 MHz / 115200); legal values are 4 and above.
REQ-002 clk  input  1  single system clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_rx  input  1  asynchronous UART serial line, idle high, 8 data bits, LSB first, 1 stop bit.
REQ-005 o_data  output  8  last correctly received byte.
REQ-006 o_valid  output  1  one-cycle pulse when o_data has been updated.
REQ-007 o_frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-008 o_parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.
REQ-009 o_word  output  16  display word, last two good bytes, newest in [7:0]; feeds the 4-digit hex display i_data.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer; FSM uses only the synchronized value (2-cycle input latency).
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP, RECOVER.
REQ-012 IDLE: a synchronized low SHALL move to START with the bit counter cleared.
REQ-013 START: at count CLKS_PER_BIT/2-1 (integer division), sample; low -> DATA with counter cleared; high -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift in LSB first; after bit 7 go to PARITY (macro) or STOP.
REQ-015 Bit-period counter SHALL be width clog2(CLKS_PER_BIT) and wrap to 0 at CLKS_PER_BIT-1; bit index is 3 bits and wraps to 0 after bit 7.
REQ-016 STOP: sample after CLKS_PER_BIT cycles; high with no parity error -> next cycle o_valid=1, o_data=byte, o_word={o_word[7:0],byte}, state IDLE.
REQ-017 STOP sampled low -> next cycle o_frame_err=1, o_data/o_word unchanged, state RECOVER.
REQ-018 RECOVER: remain until synchronized i_rx is high, then IDLE; line breaks of any length SHALL produce exactly one o_frame_err.
REQ-019 Parity error and frame error in the same frame SHALL pulse both flags in the same cycle, with no o_valid.
REQ-020 o_data and o_word SHALL hold their values between updates; o_valid, o_frame_err and o_parity_err are never high for more than one cycle.

Reset
REQ-021 rst SHALL force state IDLE, counters 0, synchronizer flops 1, o_data 0x00, o_word 0x0000, all pulse outputs 0.
REQ-022 rst asserted mid-frame SHALL abandon the frame with no pulse; if i_rx is still low after release, reception SHALL start at the next falling edge only after the line has been seen high (state RECOVER-free: IDLE treats a low line as a start, so the bench SHALL release reset with i_rx high).

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: PARITY state inserted after DATA; one bit sampled; even parity over 8 data bits plus parity bit; on mismatch, o_parity_err pulses in the o_valid slot and o_data/o_word are not updated.
REQ-024 UART_RX_PARITY_EN undefined: no PARITY state; frame is 10 bits; o_parity_err tied to 0.

Verification (CLKS_PER_BIT=16)
REQ-025 After reset, send 0x5A, valid stop -> one o_valid pulse, o_data=0x5A, o_word=0x005A.
REQ-026 Then send 0xC3 -> o_data=0xC3, o_word=0x5AC3; no error pulses.
REQ-027 Low glitch of 4 cycles on idle line -> no pulses, state back to IDLE; a following 0x11 frame is received correctly.
REQ-028 0x81 with stop bit low, line held low 3 bit times, then high -> exactly one o_frame_err pulse, o_word unchanged; the next 0x22 frame gives o_word={prev[7:0],0x22}.
REQ-029 rst pulsed during data bit 4 -> all outputs 0 next cycle; the next 0x0F frame gives o_data=0x0F, o_word=0x000F.
REQ-030 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> o_parity_err pulse, no o_valid; 0x07 with parity bit 1 -> o_valid, o_data=0x07.
